// File: rtl/exec_pkg.sv
// Shared types for the execute stage: opcodes, flag bit positions and FSM states.
// Multiply support in the datapath is enabled by defining EXEC_MUL_EN.
package exec_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_PASS = 4'd8,
        OP_MUL  = 4'd9
    } op_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_WB   = 2'd2
    } exec_state_e;

endpackage

// File: rtl/exec_unit_if.sv
// Decoder-to-execute handshake plus register-file write port and status flags.
interface exec_unit_if #(
    parameter int WIDTH   = 8,
    parameter int RADDR_W = 3
);
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [RADDR_W-1:0] dst;
    logic               wb_en;
    logic [RADDR_W-1:0] wb_addr;
    logic [WIDTH-1:0]   wb_data;
    logic [3:0]         flags;
    logic               ill_op;

    modport master (
        output in_valid, op, a, b, dst,
        input  in_ready, wb_en, wb_addr, wb_data, flags, ill_op
    );

    modport slave (
        input  in_valid, op, a, b, dst,
        output in_ready, wb_en, wb_addr, wb_data, flags, ill_op
    );
endinterface

// File: rtl/exec_mul_seq.sv
// Iterative shift-add multiplier: operands load on start, one partial product per clock.
// done is high during the final step; product then carries the completed result.
module exec_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CNT_W = $clog2(WIDTH);

    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   step_acc;

    assign step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done     = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    // Expose the in-flight step so the caller can register the product on the same edge.
    assign product  = step_acc;

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = step_acc;
            mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q + 1'b1;
            if (done) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end
endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU with registered writeback and {V,N,C,Z} flags.
// Defining EXEC_MUL_EN adds the multi-cycle multiply (opcode 9); otherwise opcode 9 is illegal.
//
// state  | meaning
// S_IDLE | ready for a new op; ALU ops complete here
// S_MUL  | multiplier stepping, decoder held off
// S_WB   | product written back this cycle, ready for a new op
module exec_unit
    import exec_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int RADDR_W = 3
) (
    input  logic          clk,
    input  logic          rst,
    exec_unit_if.slave    bus
);
    exec_state_e        state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               wb_en_q, wb_en_d;
    logic [RADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [WIDTH-1:0]   wb_data_q, wb_data_d;
    logic [3:0]         flags_q, flags_d;
    logic               ill_q, ill_d;

    op_e                op_v;
    logic               accept;
    logic [WIDTH:0]     sum_ext, diff_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v, alu_legal;
    logic [3:0]         alu_flags;

    assign op_v     = op_e'(bus.op);
    assign accept   = bus.in_valid && in_ready_q;
    assign sum_ext  = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff_ext = {1'b0, bus.a} - {1'b0, bus.b};

    always_comb begin
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_legal = 1'b1;
        case (op_v)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (sum_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = diff_ext[WIDTH];
                alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (diff_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_NOT:  alu_res = ~bus.a;
            OP_SHL: begin
                alu_res = {bus.a[WIDTH-2:0], 1'b0};
                alu_c   = bus.a[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, bus.a[WIDTH-1:1]};
                alu_c   = bus.a[0];
            end
            OP_PASS: alu_res = bus.b;
            // OP_MUL is handled by the sequencer, so it is never a legal ALU op here.
            default: alu_legal = 1'b0;
        endcase
        alu_flags         = '0;
        alu_flags[FLAG_Z] = (alu_res == '0);
        alu_flags[FLAG_N] = alu_res[WIDTH-1];
        alu_flags[FLAG_C] = alu_c;
        alu_flags[FLAG_V] = alu_v;
    end

`ifdef EXEC_MUL_EN
    logic               mul_start, mul_done, is_mul;
    logic [2*WIDTH-1:0] mul_prod;
    logic [RADDR_W-1:0] mul_dst_q, mul_dst_d;
    logic [3:0]         mul_flags;

    assign is_mul = (op_v == OP_MUL);

    exec_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        mul_flags         = '0;
        mul_flags[FLAG_Z] = (mul_prod[WIDTH-1:0] == '0);
        mul_flags[FLAG_N] = mul_prod[WIDTH-1];
        mul_flags[FLAG_C] = |mul_prod[2*WIDTH-1:WIDTH];
        mul_flags[FLAG_V] = |mul_prod[2*WIDTH-1:WIDTH];
    end
`endif

    always_comb begin
        state_d   = state_q;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        flags_d   = flags_q;
        ill_d     = 1'b0;
`ifdef EXEC_MUL_EN
        mul_start = 1'b0;
        mul_dst_d = mul_dst_q;
`endif
        if (state_q == S_MUL) begin
`ifdef EXEC_MUL_EN
            if (mul_done) begin
                state_d   = S_WB;
                wb_en_d   = 1'b1;
                wb_addr_d = mul_dst_q;
                wb_data_d = mul_prod[WIDTH-1:0];
                flags_d   = mul_flags;
            end
`endif
        end else begin
            state_d = S_IDLE;
            if (accept) begin
`ifdef EXEC_MUL_EN
                if (is_mul) begin
                    state_d   = S_MUL;
                    mul_start = 1'b1;
                    mul_dst_d = bus.dst;
                end else
`endif
                if (alu_legal) begin
                    wb_en_d   = 1'b1;
                    wb_addr_d = bus.dst;
                    wb_data_d = alu_res;
                    flags_d   = alu_flags;
                end else begin
                    ill_d = 1'b1;
                end
            end
        end
        in_ready_d = (state_d != S_MUL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            flags_q    <= '0;
            ill_q      <= 1'b0;
`ifdef EXEC_MUL_EN
            mul_dst_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            wb_en_q    <= wb_en_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            flags_q    <= flags_d;
            ill_q      <= ill_d;
`ifdef EXEC_MUL_EN
            mul_dst_q  <= mul_dst_d;
`endif
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wb_en    = wb_en_q;
    assign bus.wb_addr  = wb_addr_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.flags    = flags_q;
    assign bus.ill_op   = ill_q;
endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit; exercises the multiply path when EXEC_MUL_EN is defined.
module tb_exec_unit;
    import exec_pkg::*;

    localparam int WIDTH   = 8;
    localparam int RADDR_W = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    exec_unit_if #(.WIDTH(WIDTH), .RADDR_W(RADDR_W)) bus ();

    exec_unit #(.WIDTH(WIDTH), .RADDR_W(RADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] dst);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.dst      = dst;
    endtask

    task automatic check_wb(input string tag, input logic en, input logic [2:0] addr,
                            input logic [7:0] data, input logic [3:0] fl);
        check({tag, ".wb_en"},   16'(bus.wb_en),   16'(en));
        check({tag, ".wb_addr"}, 16'(bus.wb_addr), 16'(addr));
        check({tag, ".wb_data"}, 16'(bus.wb_data), 16'(data));
        check({tag, ".flags"},   16'(bus.flags),   16'(fl));
    endtask

    initial begin
        int seen;
        bus.in_valid = 1'b0;
        bus.op       = 4'd0;
        bus.a        = 8'h00;
        bus.b        = 8'h00;
        bus.dst      = 3'd0;
        rst = 1'b1;
        #1 rst = 1'b0;
        tick();
        tick();
        check("rst.in_ready", 16'(bus.in_ready), 16'd0);
        check("rst.ill_op",   16'(bus.ill_op),   16'd0);
        check_wb("rst", 1'b0, 3'd0, 8'h00, 4'h0);
        #2 rst = 1'b1;
        tick();
        check("post_rst.in_ready", 16'(bus.in_ready), 16'd1);

        // ADD overflow into the sign bit: V=1 N=1
        drive(4'd0, 8'h7F, 8'h01, 3'd3);
        tick();
        check_wb("add_ovf", 1'b1, 3'd3, 8'h80, 4'hC);

        // back-to-back SUBs
        drive(4'd1, 8'h05, 8'h05, 3'd1);
        tick();
        check_wb("sub_zero", 1'b1, 3'd1, 8'h00, 4'h1);
        drive(4'd1, 8'h02, 8'h05, 3'd2);
        tick();
        check_wb("sub_borrow", 1'b1, 3'd2, 8'hFD, 4'h6);

        drive(4'd6, 8'h81, 8'h00, 3'd4);
        tick();
        check_wb("shl", 1'b1, 3'd4, 8'h02, 4'h2);
        drive(4'd7, 8'h01, 8'h00, 3'd5);
        tick();
        check_wb("shr", 1'b1, 3'd5, 8'h00, 4'h3);

        drive(4'd2, 8'hF0, 8'h3C, 3'd6);
        tick();
        check_wb("and", 1'b1, 3'd6, 8'h30, 4'h0);
        drive(4'd3, 8'hF0, 8'h0F, 3'd7);
        tick();
        check_wb("or", 1'b1, 3'd7, 8'hFF, 4'h4);
        drive(4'd4, 8'hAA, 8'hAA, 3'd0);
        tick();
        check_wb("xor", 1'b1, 3'd0, 8'h00, 4'h1);
        drive(4'd5, 8'h0F, 8'h99, 3'd1);
        tick();
        check_wb("not", 1'b1, 3'd1, 8'hF0, 4'h4);
        drive(4'd8, 8'h11, 8'h7E, 3'd2);
        tick();
        check_wb("pass", 1'b1, 3'd2, 8'h7E, 4'h0);
        drive(4'd0, 8'hFF, 8'h01, 3'd3);
        tick();
        check_wb("add_carry", 1'b1, 3'd3, 8'h00, 4'h3);
        drive(4'd1, 8'h80, 8'h01, 3'd4);
        tick();
        check_wb("sub_ovf", 1'b1, 3'd4, 8'h7F, 4'h8);

        // idle cycle: strobe drops, data and flags hold
        bus.in_valid = 1'b0;
        tick();
        check_wb("idle_hold", 1'b0, 3'd4, 8'h7F, 4'h8);

        drive(4'hC, 8'h12, 8'h34, 3'd6);
        tick();
        bus.in_valid = 1'b0;
        check("ill_c.ill_op", 16'(bus.ill_op), 16'd1);
        check_wb("ill_c", 1'b0, 3'd4, 8'h7F, 4'h8);
        tick();
        check("ill_c.pulse_end", 16'(bus.ill_op), 16'd0);

`ifdef EXEC_MUL_EN
        // MUL 0x10*0x20 with the next op held valid throughout
        drive(4'd9, 8'h10, 8'h20, 3'd5);
        tick();
        drive(4'd0, 8'h01, 8'h02, 3'd6);
        check("mul.busy0.in_ready", 16'(bus.in_ready), 16'd0);
        check("mul.busy0.wb_en",    16'(bus.wb_en),    16'd0);
        for (int i = 1; i < 8; i++) begin
            tick();
            check($sformatf("mul.busy%0d.in_ready", i), 16'(bus.in_ready), 16'd0);
            check($sformatf("mul.busy%0d.wb_en", i),    16'(bus.wb_en),    16'd0);
        end
        tick();
        check_wb("mul_wb", 1'b1, 3'd5, 8'h00, 4'hB);
        check("mul_wb.in_ready", 16'(bus.in_ready), 16'd1);
        tick();
        bus.in_valid = 1'b0;
        check_wb("add_after_mul", 1'b1, 3'd6, 8'h03, 4'h0);
        check("add_after_mul.in_ready", 16'(bus.in_ready), 16'd1);

        // 0x0F*0x0D = 0x00C3: no high byte, N=1
        drive(4'd9, 8'h0F, 8'h0D, 3'd4);
        tick();
        bus.in_valid = 1'b0;
        repeat (7) tick();
        check("mul2.early.wb_en", 16'(bus.wb_en), 16'd0);
        tick();
        check_wb("mul2_wb", 1'b1, 3'd4, 8'hC3, 4'h4);

        // reset during the fourth cycle of a multiply
        drive(4'd9, 8'h03, 8'h04, 3'd7);
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b0;
        #1;
        check_wb("mul_rst", 1'b0, 3'd0, 8'h00, 4'h0);
        check("mul_rst.in_ready", 16'(bus.in_ready), 16'd0);
        tick();
        #2 rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.wb_en) seen++;
        end
        check("mul_rst.no_wb", 16'(seen), 16'd0);
        check("mul_rst.in_ready_after", 16'(bus.in_ready), 16'd1);
`else
        drive(4'd9, 8'h10, 8'h20, 3'd5);
        tick();
        bus.in_valid = 1'b0;
        check("ill_9.ill_op", 16'(bus.ill_op), 16'd1);
        check_wb("ill_9", 1'b0, 3'd4, 8'h7F, 4'h8);
        check("ill_9.in_ready", 16'(bus.in_ready), 16'd1);
        tick();
        check("ill_9.pulse_end", 16'(bus.ill_op), 16'd0);

        #2 rst = 1'b0;
        #1;
        check_wb("async_rst", 1'b0, 3'd0, 8'h00, 4'h0);
        check("async_rst.in_ready", 16'(bus.in_ready), 16'd0);
        tick();
        #2 rst = 1'b1;
        tick();
        check("async_rst.in_ready_after", 16'(bus.in_ready), 16'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
